// File: rtl/timer_ctrl_status.sv
// timer_ctrl_status
//   Register-side control and status for the two OPL3 timers. Decodes host
//   writes to bank-0 registers 0x02 (timer1 reload), 0x03 (timer2 reload) and
//   0x04 (timer control). Detects rising edges on the timer overflow levels,
//   holds sticky overflow flags subject to per-timer masks, and produces the
//   status byte and active-low IRQ.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-high
//   wr               host write strobe (one cycle per write)
//   addr[8:0]        register address, bit 8 = bank select
//   din[7:0]         write data
//   timer1_overflow  overflow level from timer1
//   timer2_overflow  overflow level from timer2
//   timer1_reg       reload value for timer1
//   timer2_reg       reload value for timer2
//   start_timer1     ST1 control bit
//   start_timer2     ST2 control bit
//   status[7:0]      {IRQ, FT1, FT2, 5'b0}
//   irq_n            active-low interrupt
module timer_ctrl_status #(
    parameter int TIMER_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic [8:0]             addr,
    input  logic [7:0]             din,
    input  logic                   timer1_overflow,
    input  logic                   timer2_overflow,
    output logic [TIMER_WIDTH-1:0] timer1_reg,
    output logic [TIMER_WIDTH-1:0] timer2_reg,
    output logic                   start_timer1,
    output logic                   start_timer2,
    output logic [7:0]             status,
    output logic                   irq_n
);

    logic wr_t1, wr_t2, wr_ctl, wr_rst, wr_mode;
    logic hist1, hist2;
    logic rise1, rise2;
    logic mt1, mt2;
    logic ft1, ft2, irq;
    logic ft1_nxt, ft2_nxt;

    // Full 9-bit compare: bank 1 aliases (e.g. 0x104) never match.
    assign wr_t1   = wr && (addr == 9'h002);
    assign wr_t2   = wr && (addr == 9'h003);
    assign wr_ctl  = wr && (addr == 9'h004);
    assign wr_rst  = wr_ctl &&  din[7];
    assign wr_mode = wr_ctl && !din[7];

    assign rise1 = timer1_overflow & ~hist1;
    assign rise2 = timer2_overflow & ~hist2;

    // Flag update. The mask used here is the registered (pre-write) value, so
    // an MT write landing with a set event is gated by the old mask. An RST
    // write dominates a coincident set event.
    always_comb begin
        ft1_nxt = ft1;
        ft2_nxt = ft2;
        if (wr_rst) begin
            ft1_nxt = 1'b0;
            ft2_nxt = 1'b0;
        end else begin
            if (rise1 && !mt1) ft1_nxt = 1'b1;
            if (rise2 && !mt2) ft2_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer1_reg   <= '0;
            timer2_reg   <= '0;
            start_timer1 <= 1'b0;
            start_timer2 <= 1'b0;
            mt1          <= 1'b0;
            mt2          <= 1'b0;
            hist1        <= 1'b0;
            hist2        <= 1'b0;
            ft1          <= 1'b0;
            ft2          <= 1'b0;
            irq          <= 1'b0;
        end else begin
            hist1 <= timer1_overflow;
            hist2 <= timer2_overflow;
            if (wr_t1) timer1_reg <= TIMER_WIDTH'(din);
            if (wr_t2) timer2_reg <= TIMER_WIDTH'(din);
            if (wr_mode) begin
                mt1          <= din[6];
                mt2          <= din[5];
                start_timer2 <= din[1];
                start_timer1 <= din[0];
            end
            ft1 <= ft1_nxt;
            ft2 <= ft2_nxt;
            // IRQ registered alongside the flags so status bits never disagree.
            irq <= ft1_nxt | ft2_nxt;
        end
    end

    assign status = {irq, ft1, ft2, 5'b0};
    assign irq_n  = ~irq;

endmodule

// File: tb/tb_timer_ctrl_status.sv
module tb_timer_ctrl_status;

    logic       clk = 1'b0;
    logic       reset, wr;
    logic [8:0] addr;
    logic [7:0] din;
    logic       timer1_overflow, timer2_overflow;
    logic [7:0] timer1_reg, timer2_reg, status;
    logic       start_timer1, start_timer2, irq_n;

    timer_ctrl_status #(.TIMER_WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .wr              (wr),
        .addr            (addr),
        .din             (din),
        .timer1_overflow (timer1_overflow),
        .timer2_overflow (timer2_overflow),
        .timer1_reg      (timer1_reg),
        .timer2_reg      (timer2_reg),
        .start_timer1    (start_timer1),
        .start_timer2    (start_timer2),
        .status          (status),
        .irq_n           (irq_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] status;
        logic       irq_n;
        logic [7:0] t1;
        logic [7:0] t2;
        logic [1:0] st;   // {start_timer2, start_timer1}
    } out_t;

    typedef struct {
        string      name;
        logic       rst;
        logic       wr;
        logic [8:0] addr;
        logic [7:0] din;
        logic       ov1;
        logic       ov2;
        out_t       exp;
    } vec_t;

    out_t exp_q[$];
    vec_t tab1[$];
    vec_t tab2[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string n, logic r, logic w, logic [8:0] a, logic [7:0] d,
                                logic o1, logic o2, logic [7:0] es, logic [7:0] et1,
                                logic [7:0] et2, logic [1:0] est);
        vec_t v;
        v.name = n; v.rst = r; v.wr = w; v.addr = a; v.din = d; v.ov1 = o1; v.ov2 = o2;
        v.exp.status = es;
        v.exp.irq_n  = ~es[7];
        v.exp.t1     = et1;
        v.exp.t2     = et2;
        v.exp.st     = est;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        out_t got, e;
        @(negedge clk);
        reset = v.rst; wr = v.wr; addr = v.addr; din = v.din;
        timer1_overflow = v.ov1; timer2_overflow = v.ov2;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        got = {status, irq_n, timer1_reg, timer2_reg, start_timer2, start_timer1};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got status=%h irq_n=%b t1=%h t2=%h st=%b, expected status=%h irq_n=%b t1=%h t2=%h st=%b",
                     v.name, got.status, got.irq_n, got.t1, got.t2, got.st,
                     e.status, e.irq_n, e.t1, e.t2, e.st);
        end
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; addr = '0; din = '0;
        timer1_overflow = 1'b0; timer2_overflow = 1'b0;

        // reset, write decode, bank select
        tab1.push_back(mk("reset0",     1, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00));
        tab1.push_back(mk("reset1",     1, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00));
        tab1.push_back(mk("wr_t1",      0, 1, 9'h002, 8'hA5, 0, 0, 8'h00, 8'hA5, 8'h00, 2'b00));
        tab1.push_back(mk("wr_t2",      0, 1, 9'h003, 8'h3C, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab1.push_back(mk("wr_ctl03",   0, 1, 9'h004, 8'h03, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b11));
        tab1.push_back(mk("bank1_104",  0, 1, 9'h104, 8'hFF, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b11));
        tab1.push_back(mk("bank1_102",  0, 1, 9'h102, 8'h00, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b11));
        tab1.push_back(mk("addr_005",   0, 1, 9'h005, 8'hFF, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b11));
        tab1.push_back(mk("no_wr_002",  0, 0, 9'h002, 8'h11, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b11));
        foreach (tab1[i]) apply(tab1[i]);

        // long overflow level: set once, RST mid-level, no re-set until next rise
        for (int i = 0; i < 50; i++) begin
            if (i == 20)
                apply(mk("lvl_rst", 0, 1, 9'h004, 8'h80, 1, 0, 8'h00, 8'hA5, 8'h3C, 2'b11));
            else
                apply(mk(i < 20 ? "lvl_held" : "lvl_after_rst", 0, 0, 9'h000, 8'h00, 1, 0,
                         i < 20 ? 8'hC0 : 8'h00, 8'hA5, 8'h3C, 2'b11));
        end
        apply(mk("lvl_fall",   0, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b11));
        apply(mk("lvl_rerise", 0, 0, 9'h000, 8'h00, 1, 0, 8'hC0, 8'hA5, 8'h3C, 2'b11));
        apply(mk("lvl_fall2",  0, 0, 9'h000, 8'h00, 0, 0, 8'hC0, 8'hA5, 8'h3C, 2'b11));

        // masking, simultaneous events, RST with din=FF, mid-operation reset
        tab2.push_back(mk("rst_clr",       0, 1, 9'h004, 8'h80, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b11));
        tab2.push_back(mk("mask_mt1",      0, 1, 9'h004, 8'h40, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("masked_ov1",    0, 0, 9'h000, 8'h00, 1, 0, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("masked_low",    0, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("ov2_set",       0, 0, 9'h000, 8'h00, 0, 1, 8'hA0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("ov2_low",       0, 0, 9'h000, 8'h00, 0, 0, 8'hA0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("unmask_sticky", 0, 1, 9'h004, 8'h00, 0, 0, 8'hA0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("ov1_set",       0, 0, 9'h000, 8'h00, 1, 0, 8'hE0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("ov1_low",       0, 0, 9'h000, 8'h00, 0, 0, 8'hE0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("rst_vs_rise",   0, 1, 9'h004, 8'h80, 0, 1, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("lost_low",      0, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("next_rise",     0, 0, 9'h000, 8'h00, 0, 1, 8'hA0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("next_low",      0, 0, 9'h000, 8'h00, 0, 0, 8'hA0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("rst_clr2",      0, 1, 9'h004, 8'h80, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("mt_on_w_rise",  0, 1, 9'h004, 8'h20, 0, 1, 8'hA0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("mt_on_low",     0, 0, 9'h000, 8'h00, 0, 0, 8'hA0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("rst_clr3",      0, 1, 9'h004, 8'h80, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("mt2_masked",    0, 0, 9'h000, 8'h00, 0, 1, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("mt2_low",       0, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("mt_off_w_rise", 0, 1, 9'h004, 8'h00, 0, 1, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("mt_off_low",    0, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("unmasked_rise", 0, 0, 9'h000, 8'h00, 0, 1, 8'hA0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("unmasked_low",  0, 0, 9'h000, 8'h00, 0, 0, 8'hA0, 8'hA5, 8'h3C, 2'b00));
        tab2.push_back(mk("start_both",    0, 1, 9'h004, 8'h03, 0, 0, 8'hA0, 8'hA5, 8'h3C, 2'b11));
        tab2.push_back(mk("rst_ff_hold",   0, 1, 9'h004, 8'hFF, 0, 0, 8'h00, 8'hA5, 8'h3C, 2'b11));
        tab2.push_back(mk("mt1_still_off", 0, 0, 9'h000, 8'h00, 1, 0, 8'hC0, 8'hA5, 8'h3C, 2'b11));
        tab2.push_back(mk("ov1_low2",      0, 0, 9'h000, 8'h00, 0, 0, 8'hC0, 8'hA5, 8'h3C, 2'b11));
        tab2.push_back(mk("both_flags",    0, 0, 9'h000, 8'h00, 0, 1, 8'hE0, 8'hA5, 8'h3C, 2'b11));
        tab2.push_back(mk("mid_reset",     1, 1, 9'h004, 8'h03, 1, 1, 8'h00, 8'h00, 8'h00, 2'b00));
        tab2.push_back(mk("post_reset",    0, 0, 9'h000, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00));
        foreach (tab2[i]) apply(tab2[i]);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
